// File: rtl/host_bus_pkg.sv
// Shared types and constants for the host parallel bus master.
package host_bus_pkg;

    localparam int HOST_ADDR_W = 21;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } bus_state_e;

    localparam logic [HOST_ADDR_W-1:0] REG_CONSTK = 21'h00000;
    localparam logic [HOST_ADDR_W-1:0] REG_CONST1 = 21'h00008;
    localparam logic [HOST_ADDR_W-1:0] REG_CONST2 = 21'h00010;
    localparam logic [HOST_ADDR_W-1:0] REG_CMD    = 21'h01000;

    // Phase counters count down to zero, so a phase of N cycles loads N-1.
    function automatic logic [3:0] phase_load(input int cyc);
        return (cyc > 0) ? 4'(cyc - 1) : 4'd0;
    endfunction

endpackage

// File: rtl/host_bus_master_if.sv
// Request/response and host-bus signal bundle for host_bus_master.
// The 64-bit burst fields exist only when HOST_MST_WIDE64_EN is defined.
interface host_bus_master_if
    import host_bus_pkg::*;
#(
    parameter int ADDR_W = HOST_ADDR_W
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [15:0]       req_wdata;
    logic              rsp_valid;
    logic [15:0]       rsp_rdata;
    logic              HOST_nCS;
    logic              HOST_nWE;
    logic              HOST_nOE;
    logic [ADDR_W-1:0] HOST_ADD;
    logic [15:0]       HDI;
    logic [15:0]       HDO;
`ifdef HOST_MST_WIDE64_EN
    logic              req_wide;
    logic [63:0]       req_wdata64;
    logic [63:0]       rsp_rdata64;
`endif

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, HDO,
`ifdef HOST_MST_WIDE64_EN
        input  req_wide, req_wdata64,
        output rsp_rdata64,
`endif
        output req_ready, rsp_valid, rsp_rdata, HOST_nCS, HOST_nWE, HOST_nOE, HOST_ADD, HDI
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, HDO,
`ifdef HOST_MST_WIDE64_EN
        output req_wide, req_wdata64,
        input  rsp_rdata64,
`endif
        input  req_ready, rsp_valid, rsp_rdata, HOST_nCS, HOST_nWE, HOST_nOE, HOST_ADD, HDI
    );

endinterface

// File: rtl/host_bus_phase_cnt.sv
// Loadable 4-bit down-counter with zero flag; stops at zero.
module host_bus_phase_cnt (
    input  logic       clk,
    input  logic       nRESET,
    input  logic       load,
    input  logic       dec,
    input  logic [3:0] load_val,
    output logic       zero
);
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    // Next count: load wins over decrement.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (!nRESET) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == 4'd0);

endmodule

// File: rtl/host_bus_master.sv
// Host parallel bus initiator: single-word requests become SETUP/STROBE/HOLD chip-select cycles.
// Define HOST_MST_WIDE64_EN to add 64-bit requests issued as four halfword cycles.
module host_bus_master
    import host_bus_pkg::*;
#(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1,
    parameter int ADDR_W     = HOST_ADDR_W
) (
    input  logic              clk,
    input  logic              nRESET,
    host_bus_master_if.master bus
);
    localparam logic [3:0] SETUP_LD  = phase_load(SETUP_CYC);
    localparam logic [3:0] STROBE_LD = phase_load(STROBE_CYC);
    localparam logic [3:0] HOLD_LD   = phase_load(HOLD_CYC);

    bus_state_e        state_q, state_d;
    logic              ncs_q, ncs_d;
    logic              nwe_q, nwe_d;
    logic              noe_q, noe_d;
    logic              write_q, write_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       hdi_q, hdi_d;
    logic [15:0]       rdata_q, rdata_d;

    logic              ph_load_s, ph_dec_s, ph_zero_s;
    logic [3:0]        ph_val_s;
    logic              req_ready_s, accept_s, cont_s, start_s, done_s;
    logic              unused_s;

`ifdef HOST_MST_WIDE64_EN
    logic              wide_q, wide_d;
    logic [63:0]       wdata64_q, wdata64_d;
    logic [63:0]       acc_q, acc_d;
    logic [63:0]       rdata64_q, rdata64_d;
    logic              hw_load_s, hw_dec_s, hw_zero_s;

    // A burst in progress keeps the request side closed and restarts from IDLE itself.
    assign req_ready_s = (state_q == ST_IDLE) && !wide_q;
    assign cont_s      = (state_q == ST_IDLE) && wide_q;

    host_bus_phase_cnt u_hw_cnt (
        .clk      (clk),
        .nRESET   (nRESET),
        .load     (hw_load_s),
        .dec      (hw_dec_s),
        .load_val (4'd3),
        .zero     (hw_zero_s)
    );
`else
    assign req_ready_s = (state_q == ST_IDLE);
    assign cont_s      = 1'b0;
`endif

    assign accept_s = req_ready_s && bus.req_valid;
    assign start_s  = accept_s || cont_s;
    assign unused_s = bus.req_addr[0];

    host_bus_phase_cnt u_phase_cnt (
        .clk      (clk),
        .nRESET   (nRESET),
        .load     (ph_load_s),
        .dec      (ph_dec_s),
        .load_val (ph_val_s),
        .zero     (ph_zero_s)
    );

    // Request latching, phase sequencing and completion.
    always_comb begin
        state_d     = state_q;
        ncs_d       = ncs_q;
        nwe_d       = nwe_q;
        noe_d       = noe_q;
        write_d     = write_q;
        addr_d      = addr_q;
        hdi_d       = hdi_q;
        rdata_d     = rdata_q;
        rsp_valid_d = 1'b0;
        ph_load_s   = 1'b0;
        ph_dec_s    = 1'b0;
        ph_val_s    = 4'd0;
        done_s      = 1'b0;
`ifdef HOST_MST_WIDE64_EN
        wide_d      = wide_q;
        wdata64_d   = wdata64_q;
        acc_d       = acc_q;
        rdata64_d   = rdata64_q;
        hw_load_s   = 1'b0;
        hw_dec_s    = 1'b0;
`endif

        if (accept_s) begin
            write_d = bus.req_write;
            addr_d  = {bus.req_addr[ADDR_W-1:1], 1'b0};
            hdi_d   = bus.req_wdata;
`ifdef HOST_MST_WIDE64_EN
            wide_d    = bus.req_wide;
            hw_load_s = bus.req_wide;
            if (bus.req_wide) begin
                hdi_d     = bus.req_wdata64[15:0];
                wdata64_d = {16'h0000, bus.req_wdata64[63:16]};
            end else begin
                wdata64_d = wdata64_q;
            end
`endif
        end else if (cont_s) begin
`ifdef HOST_MST_WIDE64_EN
            addr_d    = addr_q + ADDR_W'(2'd2);
            hdi_d     = wdata64_q[15:0];
            wdata64_d = {16'h0000, wdata64_q[63:16]};
`endif
        end else begin
            addr_d = addr_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_s) begin
                    ncs_d     = 1'b0;
                    ph_load_s = 1'b1;
                    if (SETUP_CYC == 0) begin
                        state_d  = ST_STROBE;
                        ph_val_s = STROBE_LD;
                        nwe_d    = !write_d;
                        noe_d    = write_d;
                    end else begin
                        state_d  = ST_SETUP;
                        ph_val_s = SETUP_LD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (ph_zero_s) begin
                    state_d   = ST_STROBE;
                    ph_load_s = 1'b1;
                    ph_val_s  = STROBE_LD;
                    nwe_d     = !write_q;
                    noe_d     = write_q;
                end else begin
                    ph_dec_s = 1'b1;
                end
            end
            ST_STROBE: begin
                if (ph_zero_s) begin
                    nwe_d = 1'b1;
                    noe_d = 1'b1;
                    // Slave read data is registered, so HDO is valid by the last strobe cycle.
                    if (!write_q) begin
                        rdata_d = bus.HDO;
`ifdef HOST_MST_WIDE64_EN
                        acc_d = {bus.HDO, acc_q[63:16]};
`endif
                    end else begin
                        rdata_d = rdata_q;
                    end
                    if (HOLD_CYC == 0) begin
                        done_s = 1'b1;
                    end else begin
                        state_d   = ST_HOLD;
                        ph_load_s = 1'b1;
                        ph_val_s  = HOLD_LD;
                    end
                end else begin
                    ph_dec_s = 1'b1;
                end
            end
            ST_HOLD: begin
                if (ph_zero_s) begin
                    done_s = 1'b1;
                end else begin
                    ph_dec_s = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ncs_d   = 1'b1;
                nwe_d   = 1'b1;
                noe_d   = 1'b1;
            end
        endcase

        if (done_s) begin
            state_d = ST_IDLE;
            ncs_d   = 1'b1;
`ifdef HOST_MST_WIDE64_EN
            if (wide_q && !hw_zero_s) begin
                hw_dec_s = 1'b1;
            end else begin
                rsp_valid_d = 1'b1;
                wide_d      = 1'b0;
                if (wide_q && !write_q) begin
                    rdata64_d = acc_d;
                end else begin
                    rdata64_d = rdata64_q;
                end
            end
`else
            rsp_valid_d = 1'b1;
`endif
        end else begin
            rsp_valid_d = 1'b0;
        end
    end

    // State and registered bus outputs.
    always_ff @(posedge clk) begin
        if (!nRESET) begin
            state_q     <= ST_IDLE;
            ncs_q       <= 1'b1;
            nwe_q       <= 1'b1;
            noe_q       <= 1'b1;
            write_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            addr_q      <= '0;
            hdi_q       <= 16'h0000;
            rdata_q     <= 16'h0000;
`ifdef HOST_MST_WIDE64_EN
            wide_q      <= 1'b0;
            wdata64_q   <= 64'h0;
            acc_q       <= 64'h0;
            rdata64_q   <= 64'h0;
`endif
        end else begin
            state_q     <= state_d;
            ncs_q       <= ncs_d;
            nwe_q       <= nwe_d;
            noe_q       <= noe_d;
            write_q     <= write_d;
            rsp_valid_q <= rsp_valid_d;
            addr_q      <= addr_d;
            hdi_q       <= hdi_d;
            rdata_q     <= rdata_d;
`ifdef HOST_MST_WIDE64_EN
            wide_q      <= wide_d;
            wdata64_q   <= wdata64_d;
            acc_q       <= acc_d;
            rdata64_q   <= rdata64_d;
`endif
        end
    end

    assign bus.req_ready = req_ready_s;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.HOST_nCS  = ncs_q;
    assign bus.HOST_nWE  = nwe_q;
    assign bus.HOST_nOE  = noe_q;
    assign bus.HOST_ADD  = addr_q;
    assign bus.HDI       = hdi_q;
`ifdef HOST_MST_WIDE64_EN
    assign bus.rsp_rdata64 = rdata64_q;
`endif

endmodule
